// File: rtl/axi_memory_slave.sv
// AXI4 memory slave: MEM_DEPTH words of byte-strobed storage with independent single-outstanding read/write FSMs.
// Optional AXI_MEM_SLAVE_RANGE_CHECK_EN suppresses beats whose word index is >= MEM_DEPTH and answers SLVERR.
module axi_memory_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SHIFT  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
    localparam int unsigned WA_W   = ADDR_WIDTH;
`else
    localparam int unsigned WA_W   = IDX_W;
`endif
    localparam logic [2:0] FULL_SIZE = 3'(SHIFT);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [WA_W-1:0]       w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic                  w_fixed_q, w_fixed_d;
    logic                  w_bad_size_q, w_bad_size_d;
    logic                  w_slverr_q, w_slverr_d;
    logic [ID_WIDTH-1:0]   bid_d;
    logic [1:0]            bresp_d;
    logic                  mem_we_c;
    logic                  w_oob_c;

    r_state_t              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [WA_W-1:0]       r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic                  r_fixed_q, r_fixed_d;
    logic                  r_bad_size_q, r_bad_size_d;
    logic                  r_fetch_c;
    logic                  r_oob_c;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;
    logic                  rlast_d;

    // wlast carries no meaning here: bursts end on the beat counter alone
    logic unused_c;
    assign unused_c = wlast;

    // Word indices past the array only matter when the range check is built in
`ifdef AXI_MEM_SLAVE_RANGE_CHECK_EN
    assign w_oob_c = (w_addr_q >> IDX_W) != '0;
    assign r_oob_c = (r_addr_d >> IDX_W) != '0;
`else
    assign w_oob_c = 1'b0;
    assign r_oob_c = 1'b0;
`endif

    // Write path next-state
    always_comb begin
        w_state_d    = w_state_q;
        w_id_d       = w_id_q;
        w_addr_d     = w_addr_q;
        w_len_d      = w_len_q;
        w_beat_d     = w_beat_q;
        w_fixed_d    = w_fixed_q;
        w_bad_size_d = w_bad_size_q;
        w_slverr_d   = w_slverr_q;
        bid_d        = bid;
        bresp_d      = bresp;
        mem_we_c     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    w_id_d       = awid;
                    w_addr_d     = WA_W'(awaddr >> SHIFT);
                    w_len_d      = awlen;
                    w_fixed_d    = (awburst == 2'b00);
                    w_bad_size_d = (awsize != FULL_SIZE);
                    w_slverr_d   = (awsize != FULL_SIZE);
                    w_beat_d     = 8'd0;
                    w_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    mem_we_c   = resetn && !w_bad_size_q && !w_oob_c;
                    w_slverr_d = w_slverr_q | w_oob_c;
                    w_addr_d   = w_fixed_q ? w_addr_q : WA_W'(w_addr_q + 1'b1);
                    w_beat_d   = 8'(w_beat_q + 8'd1);
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                        bid_d     = w_id_q;
                        bresp_d   = w_slverr_d ? RESP_SLV : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path next-state; the fetch reads memory before any same-edge write lands
    always_comb begin
        r_state_d    = r_state_q;
        r_id_d       = r_id_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_beat_d     = r_beat_q;
        r_fixed_d    = r_fixed_q;
        r_bad_size_d = r_bad_size_q;
        rlast_d      = rlast;
        r_fetch_c    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_id_d       = arid;
                    r_addr_d     = WA_W'(araddr >> SHIFT);
                    r_len_d      = arlen;
                    r_fixed_d    = (arburst == 2'b00);
                    r_bad_size_d = (arsize != FULL_SIZE);
                    r_beat_d     = 8'd0;
                    rlast_d      = (arlen == 8'd0);
                    r_fetch_c    = 1'b1;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (r_beat_q == r_len_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d  = r_fixed_q ? r_addr_q : WA_W'(r_addr_q + 1'b1);
                        r_beat_d  = 8'(r_beat_q + 8'd1);
                        rlast_d   = (r_beat_d == r_len_q);
                        r_fetch_c = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata;
        rresp_d = rresp;
        if (r_fetch_c) begin
            rdata_d = (r_bad_size_d || r_oob_c) ? '0 : mem[r_addr_d[IDX_W-1:0]];
            rresp_d = (r_bad_size_d || r_oob_c) ? RESP_SLV : RESP_OKAY;
        end
    end

    // State, context and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q    <= W_IDLE;
            w_id_q       <= '0;
            w_addr_q     <= '0;
            w_len_q      <= '0;
            w_beat_q     <= '0;
            w_fixed_q    <= 1'b0;
            w_bad_size_q <= 1'b0;
            w_slverr_q   <= 1'b0;
            r_state_q    <= R_IDLE;
            r_id_q       <= '0;
            r_addr_q     <= '0;
            r_len_q      <= '0;
            r_beat_q     <= '0;
            r_fixed_q    <= 1'b0;
            r_bad_size_q <= 1'b0;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bid          <= '0;
            bresp        <= '0;
            arready      <= 1'b0;
            rvalid       <= 1'b0;
            rid          <= '0;
            rdata        <= '0;
            rresp        <= '0;
            rlast        <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            w_id_q       <= w_id_d;
            w_addr_q     <= w_addr_d;
            w_len_q      <= w_len_d;
            w_beat_q     <= w_beat_d;
            w_fixed_q    <= w_fixed_d;
            w_bad_size_q <= w_bad_size_d;
            w_slverr_q   <= w_slverr_d;
            r_state_q    <= r_state_d;
            r_id_q       <= r_id_d;
            r_addr_q     <= r_addr_d;
            r_len_q      <= r_len_d;
            r_beat_q     <= r_beat_d;
            r_fixed_q    <= r_fixed_d;
            r_bad_size_q <= r_bad_size_d;
            awready      <= (w_state_d == W_IDLE);
            wready       <= (w_state_d == W_DATA);
            bvalid       <= (w_state_d == W_RESP);
            bid          <= bid_d;
            bresp        <= bresp_d;
            arready      <= (r_state_d == R_IDLE);
            rvalid       <= (r_state_d == R_DATA);
            rid          <= r_id_d;
            rdata        <= rdata_d;
            rresp        <= rresp_d;
            rlast        <= rlast_d;
        end
    end

    // Storage is never reset; only strobed bytes are updated
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_addr_q[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule
